// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its run-detector partner.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int RUN_LEN = 4;
    localparam int RUN_W   = $clog2(RUN_LEN + 1);

endpackage

// File: rtl/seq_tx_run_cnt.sv
// Saturating run-length counter over the emitted bit stream, with the previous-bit register.
module run_cnt
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic             bit_i,
    input  logic             clr_i,
    output logic             run4_o,
    output logic [RUN_W-1:0] count_o
);

    logic [RUN_W-1:0] count_q, count_d;
    logic             prev_q, prev_d;

    always_comb begin
        count_d = count_q;
        prev_d  = prev_q;
        if (clr_i) begin
            count_d = '0;
        end else if (strobe_i) begin
            // A zero count means no history yet, so the first bit after IDLE always starts a new run.
            if ((bit_i == prev_q) && (count_q != '0)) begin
                count_d = (count_q == RUN_W'(RUN_LEN)) ? count_q : count_q + 1'b1;
            end else begin
                count_d = RUN_W'(1);
            end
            prev_d = bit_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            prev_q  <= prev_d;
        end
    end

    assign run4_o  = (count_q == RUN_W'(RUN_LEN));
    assign count_o = count_q;

endmodule

// File: rtl/seq_tx.sv
// Serial transmitter: parallel words in over valid/ready, shifted out MSB-first with a
// programmable bit period, plus a flag for four identical consecutive output bits.
module seq_tx
    import seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_en,
    output logic             bit_strobe,
    output logic             busy,
    output logic             run4
);

    localparam int BCW = $clog2(DW);

    state_t           state_q, state_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0] percnt_q, percnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic             in_shift;
    logic             last_cycle;
    logic             last_bit;
    logic             accept;
    logic             bit_adv;
    logic             run_strobe;
    logic             run_bit;
    logic             run_clr;
    logic             run4_w;
    logic [RUN_W-1:0] run_count;

    assign in_shift   = (state_q == SHIFT);
    assign last_cycle = in_shift && (percnt_q == div_q);
    assign last_bit   = last_cycle && (bitcnt_q == '0);
    assign bit_adv    = last_cycle && (bitcnt_q != '0);
    assign in_ready   = !in_shift || last_bit;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        percnt_d = percnt_q;
        div_d    = div_q;
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = in_data;
            div_d    = div;
            bitcnt_d = BCW'(DW - 1);
            percnt_d = '0;
        end else if (in_shift) begin
            if (last_cycle) begin
                percnt_d = '0;
                if (last_bit) begin
                    state_d = IDLE;
                end else begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - 1'b1;
                end
            end else begin
                percnt_d = percnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            percnt_q <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            percnt_q <= percnt_d;
            div_q    <= div_d;
        end
    end

    assign dout       = in_shift && shreg_q[DW-1];
    assign dout_en    = in_shift;
    assign busy       = in_shift;
    assign bit_strobe = in_shift && (percnt_q == '0);

    // The run counter sees each bit on the edge that puts it on dout, so run4 lines up with bit_strobe.
    assign run_strobe = accept || bit_adv;
    assign run_bit    = accept ? in_data[DW-1] : shreg_q[DW-2];
    assign run_clr    = last_bit && !accept && (run_count != '0);

    run_cnt u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (run_strobe),
        .bit_i    (run_bit),
        .clr_i    (run_clr),
        .run4_o   (run4_w),
        .count_o  (run_count)
    );

    assign run4 = run4_w;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: directed vector table, multi-cycle corner cases and a
// randomized run against a behavioural stream model.
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] div;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, dout, dout_en, bit_strobe, busy, run4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_tx #(.DW(8), .DIV_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .div        (div),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_en    (dout_en),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .run4       (run4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp_v, $time);
    endtask

    // Stream model: accepted words in order, last four emitted bits since the last idle gap.
    logic [7:0] exp_data_q[$];
    logic [3:0] exp_div_q[$];
    logic       hist[$];
    int         nb = 0;
    int         len = 0;
    bit         pend = 0;
    logic [7:0] cur = '0;
    logic [7:0] wdata = '0;
    logic [3:0] wdiv = '0;
    logic [3:0] pdiv = '0;
    logic       exp_r4;

    always @(negedge clk) begin
        if (rst) begin
            exp_data_q.delete();
            exp_div_q.delete();
            hist.delete();
            nb   = 0;
            len  = 0;
            pend = 0;
        end else begin
            if (pend && (!dout_en || bit_strobe)) begin
                chk("bit_len", len, 32'(pdiv) + 1);
                pend = 0;
            end
            if (!dout_en) begin
                hist.delete();
                if (nb != 0) begin
                    chk("word_truncated_bits", nb, 0);
                    nb = 0;
                end
            end
            if (dout_en && bit_strobe) begin
                if (nb == 0) begin
                    if (exp_data_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                        wdata = '0;
                        wdiv  = '0;
                    end else begin
                        wdata = exp_data_q.pop_front();
                        wdiv  = exp_div_q.pop_front();
                    end
                end
                cur = {cur[6:0], dout};
                nb++;
                hist.push_back(dout);
                if (hist.size() > 4) void'(hist.pop_front());
                pend = 1;
                len  = 0;
                pdiv = wdiv;
                if (nb == 8) begin
                    chk("word", cur, wdata);
                    nb = 0;
                end
            end
            if (dout_en) len++;
            exp_r4 = (hist.size() == 4) && (hist[0] == hist[1]) &&
                     (hist[1] == hist[2]) && (hist[2] == hist[3]);
            chk("run4_model", run4, exp_r4);
            if (in_valid && in_ready) begin
                exp_data_q.push_back(in_data);
                exp_div_q.push_back(div);
            end
        end
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] dv;
        logic [5:0] exp; // {in_ready, dout, dout_en, bit_strobe, busy, run4}
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [7:0] d, input logic [3:0] dv,
                           input logic rdy, input logic o, input logic en,
                           input logic st, input logic bsy, input logic r4);
        vec_t t;
        t.v   = v;
        t.d   = d;
        t.dv  = dv;
        t.exp = {rdy, o, en, st, bsy, r4};
        vecs.push_back(t);
    endtask

    task automatic count_word(output int n, output int s);
        bit done = 0;
        n = 0;
        s = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            s += int'(bit_strobe);
            if (in_ready) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk(name, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int n, s;

        // A5 at div 0, no run of four anywhere.
        add_vec(1, 8'hA5, 0, 1, 0, 0, 0, 0, 0);
        w = 8'hA5;
        for (int k = 0; k < 8; k++) add_vec(0, 8'h00, 0, k == 7, w[7-k], 1, 1, 1, 0);
        add_vec(0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        // F0 at div 2: three cycles per bit, run4 on the 4th and 8th bits.
        add_vec(1, 8'hF0, 2, 1, 0, 0, 0, 0, 0);
        w = 8'hF0;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 3; c++)
                add_vec(0, 8'h00, 2, (k == 7) && (c == 2), w[7-k], 1, c == 0, 1, (k == 3) || (k == 7));
        add_vec(0, 8'h00, 2, 1, 0, 0, 0, 0, 0);
        // 0F then F0 back-to-back at div 0; the run of ones spans the boundary.
        add_vec(1, 8'h0F, 0, 1, 0, 0, 0, 0, 0);
        w = 8'h0F;
        for (int k = 0; k < 8; k++)
            add_vec(k == 7, 8'hF0, 0, k == 7, w[7-k], 1, 1, 1, (k == 3) || (k == 7));
        w = 8'hF0;
        for (int k = 0; k < 8; k++)
            add_vec(0, 8'h00, 0, k == 7, w[7-k], 1, 1, 1, (k <= 3) || (k == 7));
        add_vec(0, 8'h00, 0, 1, 0, 0, 0, 0, 0);

        // Reset held with in_valid high.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        div      = 4'd0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {in_ready, dout, dout_en, bit_strobe, busy, run4}, 6'b100000);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            div      = vecs[i].dv;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {in_ready, dout, dout_en, bit_strobe, busy, run4}, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // div changed from 1 to 3 while word 1 is in flight.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        div      = 4'd1;
        @(negedge clk);
        chk("div_change_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 8'hC3;
        div     = 4'd3;
        count_word(n, s);
        chk("div_w1_cycles", n, 16);
        chk("div_w1_strobes", s, 8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        count_word(n, s);
        chk("div_w2_cycles", n, 32);
        chk("div_w2_strobes", s, 8);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("div_idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of the 4th bit of FF.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        div      = 4'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        chk("pre_rst_active", {dout, dout_en, busy, run4}, 4'b1111);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {in_ready, dout, dout_en, bit_strobe, busy, run4}, 6'b100000);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        div      = 4'd0;
        @(negedge clk);
        chk("post_rst_idle", {in_ready, busy}, 2'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_msb", {dout, dout_en, bit_strobe}, 3'b111);
        @(posedge clk);
        #1;
        wait_idle("post_rst_drain");

        // Random words, periods and valid gaps against the stream model.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            div      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle("random_drain");
        chk("scoreboard_empty", exp_data_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
